// File: rtl/graphics_pkg.sv
// Shared types and constants for the pattern-generating display core.
package graphics_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  // Bar colours as {r,g,b} on/off flags; index 0 is the leftmost bar (white).
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/video_timing.sv
// Parametrised raster counters: x/y position plus the region flags derived from them.
module video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_vis,
  output logic        o_hs_act,
  output logic        o_vs_act,
  output logic        o_line_end,
  output logic        o_frame_end,
  output logic        o_vblank_start
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] X_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] Y_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        w_line_end;

  assign w_line_end = (r_x == X_LAST);

  // NOTE: non-blocking so x and y both advance from the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_line_end) begin
      r_x <= '0;
      r_y <= (r_y == Y_LAST) ? 16'd0 : r_y + 16'd1;
    end else begin
      r_x <= r_x + 16'd1;
    end
  end

  assign o_x            = r_x;
  assign o_y            = r_y;
  assign o_vis          = (r_x < X_ACT) && (r_y < Y_ACT);
  assign o_hs_act       = (r_x >= HS_BEG) && (r_x < HS_END);
  assign o_vs_act       = (r_y >= VS_BEG) && (r_y < VS_END);
  assign o_line_end     = w_line_end;
  assign o_frame_end    = w_line_end && (r_y == Y_LAST);
  assign o_vblank_start = (r_x == 16'd0) && (r_y == Y_ACT);

endmodule

// File: rtl/display_core.sv
// Graphics core top: raster timing, per-frame pattern selection, aligned output
// pipeline and a latched vblank interrupt.
module display_core
  import graphics_pkg::*;
#(
  parameter int   H_ACTIVE    = 1280,
  parameter int   H_FP        = 110,
  parameter int   H_SYNC      = 40,
  parameter int   H_BP        = 220,
  parameter int   V_ACTIVE    = 720,
  parameter int   V_FP        = 5,
  parameter int   V_SYNC      = 5,
  parameter int   V_BP        = 20,
  parameter logic HSYNC_POL   = 1'b1,
  parameter logic VSYNC_POL   = 1'b1,
  parameter int   COLOR_BITS  = 4,
  parameter int   CHECK_SHIFT = 5,
  parameter int   PIPE_DEPTH  = 2
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic [1:0]            mode_req,
  input  logic                  mode_we,
  input  logic                  int_ack,
  output logic                  disp_clk,
  output logic                  disp_hsync,
  output logic                  disp_vsync,
  output logic                  disp_de,
  output logic [COLOR_BITS-1:0] disp_r,
  output logic [COLOR_BITS-1:0] disp_g,
  output logic [COLOR_BITS-1:0] disp_b,
  output logic [1:0]            mode_active,
  output logic [15:0]           frame_count,
  output logic                  int_vblank
);

  typedef struct packed {
    logic                  hs;
    logic                  vs;
    logic                  de;
    logic                  vbl;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } bus_t;

  localparam bus_t BUS_IDLE = bus_t'({~HSYNC_POL, ~VSYNC_POL, {(2 + 3 * COLOR_BITS){1'b0}}});
  localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);

  logic [15:0] w_x;
  logic [15:0] w_y;
  logic        w_vis;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_vblank_start;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk          (pixel_clk),
    .i_reset        (reset),
    .o_x            (w_x),
    .o_y            (w_y),
    .o_vis          (w_vis),
    .o_hs_act       (w_hs_act),
    .o_vs_act       (w_vs_act),
    .o_line_end     (w_line_end),
    .o_frame_end    (w_frame_end),
    .o_vblank_start (w_vblank_start)
  );

  // Bar position tracked alongside x so no divider is needed for the bar index.
  logic [15:0] r_bar_pix;
  logic [2:0]  r_bar_idx;

  always_ff @(posedge pixel_clk) begin
    if (reset || w_line_end) begin
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_pix == BAR_LAST) begin
      r_bar_pix <= '0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_pix <= r_bar_pix + 16'd1;
    end
  end

  mode_e       r_mode_pend;
  mode_e       r_mode_act;
  logic [15:0] r_frame_cnt;

  // A write on the boundary cycle lands in pending only; active takes the old pending.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_mode_pend <= MODE_BLACK;
      r_mode_act  <= MODE_BLACK;
      r_frame_cnt <= '0;
    end else begin
      if (mode_we) begin
        r_mode_pend <= mode_e'(mode_req);
      end
      if (w_frame_end) begin
        r_mode_act  <= r_mode_pend;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  bus_t w_stage0;

  always_comb begin
    // NOTE: whole struct defaulted first so no field can infer a latch.
    w_stage0     = '0;
    w_stage0.hs  = w_hs_act ? HSYNC_POL : ~HSYNC_POL;
    w_stage0.vs  = w_vs_act ? VSYNC_POL : ~VSYNC_POL;
    w_stage0.de  = w_vis;
    w_stage0.vbl = w_vblank_start;
    if (w_vis) begin
      unique case (r_mode_act)
        MODE_BARS: begin
          w_stage0.r = {COLOR_BITS{BAR_RGB[r_bar_idx][2]}};
          w_stage0.g = {COLOR_BITS{BAR_RGB[r_bar_idx][1]}};
          w_stage0.b = {COLOR_BITS{BAR_RGB[r_bar_idx][0]}};
        end
        MODE_CHECKER: begin
          if (w_x[CHECK_SHIFT] ^ w_y[CHECK_SHIFT]) begin
            w_stage0.r = '1;
            w_stage0.g = '1;
            w_stage0.b = '1;
          end
        end
        MODE_GRADIENT: begin
          w_stage0.r = w_x[COLOR_BITS+3:4];
          w_stage0.g = w_y[COLOR_BITS+3:4];
          w_stage0.b = r_frame_cnt[COLOR_BITS-1:0];
        end
        default: ;
      endcase
    end
  end

  bus_t [PIPE_DEPTH-1:0] r_pipe;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      // NOTE: every stage is reset so the bus goes idle on the very next cycle.
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= BUS_IDLE;
      end
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  bus_t w_bus;
  logic r_int_vblank;

  assign w_bus = r_pipe[PIPE_DEPTH-1];

  // The delayed set pulse shows on the output at once and outranks an ack.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_int_vblank <= 1'b0;
    end else begin
      r_int_vblank <= w_bus.vbl | (r_int_vblank & ~int_ack);
    end
  end

  assign disp_clk    = pixel_clk;
  assign disp_hsync  = w_bus.hs;
  assign disp_vsync  = w_bus.vs;
  assign disp_de     = w_bus.de;
  assign disp_r      = w_bus.r;
  assign disp_g      = w_bus.g;
  assign disp_b      = w_bus.b;
  assign mode_active = r_mode_act;
  assign frame_count = r_frame_cnt;
  assign int_vblank  = r_int_vblank | w_bus.vbl;

  logic w_unused;
  assign w_unused = &{1'b0, w_x, w_y};

endmodule

// File: tb/tb_display_core.sv
// Self-checking bench for display_core: directed vector table plus randomized
// stimulus against a position-based reference model.
module tb_display_core;

  localparam int HA = 16, HFP = 2, HSW = 2, HBP = 4;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int PD = 2;
  localparam int CS = 1;

  logic        pixel_clk = 1'b0;
  logic        reset     = 1'b1;
  logic [1:0]  mode_req  = 2'd0;
  logic        mode_we   = 1'b0;
  logic        int_ack   = 1'b0;

  logic        clk_a, hs_a, vs_a, de_a, int_a;
  logic [3:0]  r_a, g_a, b_a;
  logic [1:0]  mode_a;
  logic [15:0] fc_a;
  logic        clk_b, hs_b, vs_b, de_b, int_b;
  logic [3:0]  r_b, g_b, b_b;
  logic [1:0]  mode_b;
  logic [15:0] fc_b;

  always #5 pixel_clk = ~pixel_clk;

  display_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_BITS(4), .CHECK_SHIFT(CS), .PIPE_DEPTH(PD)
  ) dut_a (
    .pixel_clk(pixel_clk), .reset(reset), .mode_req(mode_req), .mode_we(mode_we),
    .int_ack(int_ack), .disp_clk(clk_a), .disp_hsync(hs_a), .disp_vsync(vs_a),
    .disp_de(de_a), .disp_r(r_a), .disp_g(g_a), .disp_b(b_a),
    .mode_active(mode_a), .frame_count(fc_a), .int_vblank(int_a)
  );

  display_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .COLOR_BITS(4), .CHECK_SHIFT(CS), .PIPE_DEPTH(PD)
  ) dut_b (
    .pixel_clk(pixel_clk), .reset(reset), .mode_req(mode_req), .mode_we(mode_we),
    .int_ack(int_ack), .disp_clk(clk_b), .disp_hsync(hs_b), .disp_vsync(vs_b),
    .disp_de(de_b), .disp_r(r_b), .disp_g(g_b), .disp_b(b_b),
    .mode_active(mode_b), .frame_count(fc_b), .int_vblank(int_b)
  );

  typedef enum int {S_NONE, S_DE, S_HS, S_HS2, S_VS, S_RGB, S_MODE, S_FC, S_INT} sig_e;

  typedef struct {
    int          sess;
    int          cyc;
    logic        we;
    logic [1:0]  req;
    logic        ack;
    sig_e        sig;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic        vbl;
    logic [11:0] rgb;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   sess  = 0;
  int   cyc   = 0;
  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t m_cur;
  int   m_pend, m_act, m_fc;
  bit   m_int;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s sess=%0d cyc=%0d got=%0h want=%0h", name, sess, cyc, act, exp);
    end
  endtask

  task automatic add(input int s, input int c, input logic we, input logic [1:0] req,
                     input logic ack, input sig_e sig, input logic [15:0] exp);
    vec_t v;
    v.sess = s; v.cyc = c; v.we = we; v.req = req; v.ack = ack; v.sig = sig; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] ref_rgb(input int x, input int y, input int mode, input int fc);
    int   bar;
    logic r, g, b;
    if (x >= HA || y >= VA) return 12'h000;
    case (mode)
      1: begin
        bar = x / (HA / 8);
        r = (bar == 0 || bar == 1 || bar == 4 || bar == 5);
        g = (bar <= 3);
        b = (bar % 2 == 0);
        return {{4{r}}, {4{g}}, {4{b}}};
      end
      2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 12'hFFF : 12'h000;
      3: return {4'((x >> 4) & 15), 4'((y >> 4) & 15), 4'(fc & 15)};
      default: return 12'h000;
    endcase
  endfunction

  // Expected bus content for raster position c of the current session.
  function automatic exp_t ref_pos(input int c, input int mode, input int fc);
    exp_t e;
    int   x, y;
    x = c % HT;
    y = (c / HT) % VT;
    e.de  = (x < HA) && (y < VA);
    e.hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
    e.vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
    e.vbl = (x == 0) && (y == VA);
    e.rgb = ref_rgb(x, y, mode, fc);
    return e;
  endfunction

  function automatic logic [15:0] sig_value(input sig_e s);
    case (s)
      S_DE:    return {15'd0, de_a};
      S_HS:    return {15'd0, hs_a};
      S_HS2:   return {15'd0, hs_b};
      S_VS:    return {15'd0, vs_a};
      S_RGB:   return {4'd0, r_a, g_a, b_a};
      S_MODE:  return {14'd0, mode_a};
      S_FC:    return fc_a;
      S_INT:   return {15'd0, int_a};
      default: return 16'd0;
    endcase
  endfunction

  task automatic check_idle();
    check("rst_de", de_a, 0);
    check("rst_hsync", hs_a, 0);
    check("rst_hsync_b", hs_b, 1);
    check("rst_vsync", vs_a, 0);
    check("rst_rgb", {r_a, g_a, b_a}, 0);
    check("rst_mode", mode_a, 0);
    check("rst_fcount", fc_a, 0);
    check("rst_int", int_a, 0);
  endtask

  task automatic check_model();
    check("de", de_a, m_cur.de);
    check("hsync", hs_a, m_cur.hs);
    check("vsync", vs_a, m_cur.vs);
    check("rgb", {r_a, g_a, b_a}, m_cur.rgb);
    check("mode", mode_a, m_act);
    check("fcount", fc_a, m_fc);
    check("int", int_a, m_int | m_cur.vbl);
    check("hsync_b", hs_b, !m_cur.hs);
    check("de_b", de_b, m_cur.de);
    check("disp_clk", clk_a, 1);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1; mode_we = 1'b0; int_ack = 1'b0; mode_req = 2'd0; cyc = -1;
    for (int i = 0; i < hold; i++) begin
      @(posedge pixel_clk); #1;
      check_idle();
    end
    reset = 1'b0;
  endtask

  // Runs ncyc cycles starting at cycle 0 (first cycle after reset release).
  task automatic run_session(input int s, input int ncyc);
    exp_t idle;
    idle.hs = 0; idle.vs = 0; idle.de = 0; idle.vbl = 0; idle.rgb = 0;
    sess = s;
    m_pend = 0; m_act = 0; m_fc = 0; m_int = 0;
    exp_q.delete();
    for (int i = 0; i < PD; i++) exp_q.push_back(idle);
    for (int c = 0; c < ncyc; c++) begin
      cyc = c;
      mode_we = 1'b0; int_ack = 1'b0; mode_req = 2'd0;
      if (s == 2) begin
        int_ack = ($urandom_range(0, 9) == 0);
        if (c >= 18 * FT && $urandom_range(0, 39) == 0) begin
          mode_we  = 1'b1;
          mode_req = 2'($urandom_range(0, 3));
        end
      end
      foreach (vecs[i]) begin
        if (vecs[i].sess == s && vecs[i].cyc == c) begin
          if (vecs[i].we) begin
            mode_we  = 1'b1;
            mode_req = vecs[i].req;
          end
          if (vecs[i].ack) int_ack = 1'b1;
        end
      end
      exp_q.push_back(ref_pos(c, m_act, m_fc));
      m_cur = exp_q.pop_front();
      check_model();
      foreach (vecs[i]) begin
        if (vecs[i].sess == s && vecs[i].cyc == c && vecs[i].sig != S_NONE)
          check(vecs[i].sig.name(), sig_value(vecs[i].sig), vecs[i].exp);
      end
      if (s == 2 && c % FT == PD && c / FT >= 1 && c / FT <= 17)
        check("grad_b", b_a, (c / FT) % 16);
      if (c % FT == FT - 1) begin
        m_act = m_pend;
        m_fc  = (m_fc + 1) % 65536;
      end
      if (mode_we) m_pend = mode_req;
      m_int = m_cur.vbl | (m_int & !int_ack);
      @(posedge pixel_clk); #1;
    end
  endtask

  initial begin
    // Session 0: raster timing, bars, boundary write, interrupt.
    add(0, 100, 0, 0, 1, S_INT, 1);
    add(0, 150, 1, 1, 0, S_NONE, 0);
    add(0, 167, 1, 2, 0, S_MODE, 0);
    add(0, 266, 0, 0, 1, S_INT, 1);
    add(0, 1, 0, 0, 0, S_DE, 0);     add(0, 2, 0, 0, 0, S_DE, 1);
    add(0, 17, 0, 0, 0, S_DE, 1);    add(0, 18, 0, 0, 0, S_DE, 0);
    add(0, 25, 0, 0, 0, S_DE, 0);    add(0, 26, 0, 0, 0, S_DE, 1);
    add(0, 19, 0, 0, 0, S_HS, 0);    add(0, 20, 0, 0, 0, S_HS, 1);
    add(0, 21, 0, 0, 0, S_HS, 1);    add(0, 22, 0, 0, 0, S_HS, 0);
    add(0, 44, 0, 0, 0, S_HS, 1);    add(0, 46, 0, 0, 0, S_HS, 0);
    add(0, 20, 0, 0, 0, S_HS2, 0);   add(0, 22, 0, 0, 0, S_HS2, 1);
    add(0, 121, 0, 0, 0, S_VS, 0);   add(0, 122, 0, 0, 0, S_VS, 1);
    add(0, 145, 0, 0, 0, S_VS, 1);   add(0, 146, 0, 0, 0, S_VS, 0);
    add(0, 97, 0, 0, 0, S_INT, 0);   add(0, 98, 0, 0, 0, S_INT, 1);
    add(0, 99, 0, 0, 0, S_INT, 1);   add(0, 101, 0, 0, 0, S_INT, 0);
    add(0, 265, 0, 0, 0, S_INT, 0);  add(0, 267, 0, 0, 0, S_INT, 1);
    add(0, 168, 0, 0, 0, S_MODE, 1); add(0, 335, 0, 0, 0, S_MODE, 1);
    add(0, 336, 0, 0, 0, S_MODE, 2);
    add(0, 167, 0, 0, 0, S_FC, 0);   add(0, 168, 0, 0, 0, S_FC, 1);
    add(0, 336, 0, 0, 0, S_FC, 2);
    add(0, 170, 0, 0, 0, S_RGB, 16'hFFF); add(0, 171, 0, 0, 0, S_RGB, 16'hFFF);
    add(0, 180, 0, 0, 0, S_RGB, 16'hF00); add(0, 184, 0, 0, 0, S_RGB, 16'h000);
    add(0, 185, 0, 0, 0, S_RGB, 16'h000); add(0, 340, 0, 0, 0, S_RGB, 16'hFFF);
    add(0, 388, 0, 0, 0, S_RGB, 16'h000);
    // Session 1: first write lands on the boundary cycle.
    add(1, 167, 1, 1, 0, S_NONE, 0);
    add(1, 168, 0, 0, 0, S_MODE, 0); add(1, 335, 0, 0, 0, S_MODE, 0);
    add(1, 336, 0, 0, 0, S_MODE, 1); add(1, 336, 0, 0, 0, S_FC, 2);
    add(1, 337, 0, 0, 0, S_RGB, 16'h000); add(1, 338, 0, 0, 0, S_RGB, 16'hFFF);
    add(1, 98, 0, 0, 0, S_INT, 1);
    // Session 2: gradient from frame 1, random acks, later random mode writes.
    add(2, 0, 1, 3, 0, S_NONE, 0);
    add(2, 168, 0, 0, 0, S_MODE, 3);

    do_reset(3);
    run_session(0, 400);
    do_reset(1);
    run_session(1, 400);
    do_reset(1);
    run_session(2, 22 * FT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
